// File: rtl/hdmi_ctrl_pkg.sv
// Shared state encoding and output decode for the HDMI link bring-up sequencer.
// The encoding is visible on state_o, so the numeric values must not change.
package hdmi_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t HPD_LOW    = 3'd0;
    localparam state_t RST_HOLD   = 3'd1;
    localparam state_t WAIT_LOCK  = 3'd2;
    localparam state_t WAIT_ALIGN = 3'd3;
    localparam state_t WAIT_VS    = 3'd4;
    localparam state_t RUN        = 3'd5;
    localparam state_t FAIL       = 3'd6;
    localparam state_t HALT       = 3'd7;

    typedef struct packed {
        logic hpd;
        logic rx_rst;
        logic tx_rst_n;
        logic oen;
        logic link_up;
        logic halted;
    } link_out_t;

    localparam link_out_t LINK_OUT_RST = '{
        hpd:      1'b0,
        rx_rst:   1'b1,
        tx_rst_n: 1'b0,
        oen:      1'b0,
        link_up:  1'b0,
        halted:   1'b0
    };

    // FAIL keeps HPD high so every re-plug shows exactly HPD_LOW_CYC of low time.
    function automatic link_out_t state_outputs(input state_t st);
        link_out_t o;
        o = LINK_OUT_RST;
        case (st)
            HPD_LOW: begin
            end
            RST_HOLD: begin
                o.hpd = 1'b1;
            end
            WAIT_LOCK, WAIT_ALIGN, WAIT_VS: begin
                o.hpd    = 1'b1;
                o.rx_rst = 1'b0;
            end
            RUN: begin
                o.hpd      = 1'b1;
                o.rx_rst   = 1'b0;
                o.tx_rst_n = 1'b1;
                o.oen      = 1'b1;
                o.link_up  = 1'b1;
            end
            FAIL: begin
                o.hpd = 1'b1;
            end
            HALT: begin
                o.halted = 1'b1;
            end
            default: begin
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser, one independent chain per bit.
// Resets to zero so a freshly reset sequencer never sees a stale lock or alignment.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_reg;
    logic [W-1:0] sync_reg;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg[gi] <= 1'b0;
                    sync_reg[gi] <= 1'b0;
                end else begin
                    meta_reg[gi] <= d[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign q = sync_reg;

endmodule

// File: rtl/hdmi_link_ctrl.sv
// HDMI loopback link bring-up sequencer: hot-plug, RX reset release, lock/align/vsync
// qualification, TX enable, and re-plug with bounded retries on any link loss.
module hdmi_link_ctrl
    import hdmi_ctrl_pkg::*;
#(
    parameter int HPD_LOW_CYC   = 25_000_000,
    parameter int RST_HOLD_CYC  = 1_000,
    parameter int LOCK_TMO_CYC  = 10_000_000,
    parameter int ALIGN_TMO_CYC = 10_000_000,
    parameter int VS_TMO_CYC    = 2_500_000,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 26
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       rescan,
    input  logic       rx_pll_locked,
    input  logic       rx_align_done,
    input  logic       rx_vsync,
    output logic       hdmi_in_hpd,
    output logic       rx_rst,
    output logic       tx_rst_n,
    output logic       hdmi_out_oen,
    output logic       link_up,
    output logic       halted,
    output logic [1:0] retry_cnt,
    output logic [2:0] state_o
);

    localparam logic [CNT_W-1:0] HPD_LAST   = CNT_W'(HPD_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TMO_CYC - 1);
    localparam logic [CNT_W-1:0] ALIGN_LAST = CNT_W'(ALIGN_TMO_CYC - 1);
    localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(VS_TMO_CYC - 1);
    localparam logic [1:0]       RETRY_MAX  = 2'(MAX_RETRY);

    logic [2:0]       sync_out;
    logic             lock_s;
    logic             align_s;
    logic             vs_s;
    logic             vs_d_reg;
    logic             vs_rise;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] timer_reg;
    logic [CNT_W-1:0] timer_next;
    logic [1:0]       retry_reg;
    logic [1:0]       retry_next;
    logic [1:0]       retry_sat;
    logic             vs_seen_reg;
    logic             vs_seen_next;
    link_out_t        out_reg;

    sync_2ff #(
        .W (3)
    ) u_sync (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .d     ({rx_vsync, rx_align_done, rx_pll_locked}),
        .q     (sync_out)
    );

    assign lock_s  = sync_out[0];
    assign align_s = sync_out[1];
    assign vs_s    = sync_out[2];
    assign vs_rise = vs_s & ~vs_d_reg;

    assign retry_sat = (retry_reg == RETRY_MAX) ? retry_reg : retry_reg + 2'd1;

    // Success checks precede timeout checks, so a coincident success wins.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            HPD_LOW: begin
                if (timer_reg == HPD_LAST) state_next = RST_HOLD;
            end
            RST_HOLD: begin
                if (timer_reg == HOLD_LAST) state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s)                      state_next = WAIT_ALIGN;
                else if (timer_reg == LOCK_LAST) state_next = FAIL;
            end
            WAIT_ALIGN: begin
                if (!lock_s)                      state_next = FAIL;
                else if (align_s)                 state_next = WAIT_VS;
                else if (timer_reg == ALIGN_LAST) state_next = FAIL;
            end
            WAIT_VS: begin
                if (!lock_s || !align_s)          state_next = FAIL;
                else if (vs_rise && vs_seen_reg)  state_next = RUN;
                else if (timer_reg == VS_LAST)    state_next = FAIL;
            end
            RUN: begin
                if (!lock_s || !align_s)              state_next = FAIL;
                else if (!vs_rise && timer_reg == VS_LAST) state_next = FAIL;
            end
            FAIL: begin
                state_next = (retry_sat == RETRY_MAX) ? HALT : HPD_LOW;
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = HPD_LOW;
            end
        endcase
        if (rescan) state_next = HPD_LOW;
    end

    // The timer restarts on every state entry, on rescan, and on each vsync rise in RUN.
    always_comb begin
        timer_next = timer_reg + CNT_W'(1);
        if (rescan || (state_next != state_reg) || (state_reg == RUN && vs_rise)) begin
            timer_next = '0;
        end

        retry_next = retry_reg;
        if (rescan) begin
            retry_next = 2'd0;
        end else if (state_reg == FAIL) begin
            retry_next = retry_sat;
        end else if (state_next == RUN) begin
            retry_next = 2'd0;
        end

        // Only rises observed while already waiting count toward the two needed.
        vs_seen_next = 1'b0;
        if (state_reg == WAIT_VS && state_next == WAIT_VS) begin
            vs_seen_next = vs_seen_reg | vs_rise;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= HPD_LOW;
            timer_reg   <= '0;
            retry_reg   <= 2'd0;
            vs_seen_reg <= 1'b0;
            vs_d_reg    <= 1'b0;
            out_reg     <= LINK_OUT_RST;
        end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            retry_reg   <= retry_next;
            vs_seen_reg <= vs_seen_next;
            vs_d_reg    <= vs_s;
            out_reg     <= state_outputs(state_next);
        end
    end

    // Outputs come straight from flops decoded off state_next, so they track state_reg.
    assign hdmi_in_hpd  = out_reg.hpd;
    assign rx_rst       = out_reg.rx_rst;
    assign tx_rst_n     = out_reg.tx_rst_n;
    assign hdmi_out_oen = out_reg.oen;
    assign link_up      = out_reg.link_up;
    assign halted       = out_reg.halted;
    assign retry_cnt    = retry_reg;
    assign state_o      = state_reg;

endmodule

// File: tb/tb_hdmi_link_ctrl.sv
// Self-checking bench for hdmi_link_ctrl: a deadline-based behavioural model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_hdmi_link_ctrl;
    import hdmi_ctrl_pkg::*;

    localparam int HPD_LOW_CYC   = 100;
    localparam int RST_HOLD_CYC  = 10;
    localparam int LOCK_TMO_CYC  = 200;
    localparam int ALIGN_TMO_CYC = 200;
    localparam int VS_TMO_CYC    = 50;
    localparam int MAX_RETRY     = 3;

    logic       sys_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rescan = 1'b0;
    logic       rx_pll_locked = 1'b0;
    logic       rx_align_done = 1'b0;
    logic       rx_vsync = 1'b0;
    logic       hdmi_in_hpd;
    logic       rx_rst;
    logic       tx_rst_n;
    logic       hdmi_out_oen;
    logic       link_up;
    logic       halted;
    logic [1:0] retry_cnt;
    logic [2:0] state_o;

    hdmi_link_ctrl #(
        .HPD_LOW_CYC   (HPD_LOW_CYC),
        .RST_HOLD_CYC  (RST_HOLD_CYC),
        .LOCK_TMO_CYC  (LOCK_TMO_CYC),
        .ALIGN_TMO_CYC (ALIGN_TMO_CYC),
        .VS_TMO_CYC    (VS_TMO_CYC),
        .MAX_RETRY     (MAX_RETRY),
        .CNT_W         (26)
    ) dut (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .rescan        (rescan),
        .rx_pll_locked (rx_pll_locked),
        .rx_align_done (rx_align_done),
        .rx_vsync      (rx_vsync),
        .hdmi_in_hpd   (hdmi_in_hpd),
        .rx_rst        (rx_rst),
        .tx_rst_n      (tx_rst_n),
        .hdmi_out_oen  (hdmi_out_oen),
        .link_up       (link_up),
        .halted        (halted),
        .retry_cnt     (retry_cnt),
        .state_o       (state_o)
    );

    always #5 sys_clk = ~sys_clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    initial forever begin
        @(posedge sys_clk);
        cyc++;
    end

    // ---------------- vsync source ----------------
    bit vs_en = 1'b0;
    int vs_period = 30;
    int last_rise = 0;

    initial forever begin
        @(negedge sys_clk);
        if (vs_en) begin
            rx_vsync = 1'b1;
            last_rise = cyc;
            repeat (4) @(negedge sys_clk);
            rx_vsync = 1'b0;
            repeat (vs_period - 5) @(negedge sys_clk);
        end
    end

    // ---------------- behavioural model ----------------
    // Each phase has an absolute deadline edge; raw inputs reach the sequencer two
    // edges late, and a vsync rise is a 1 seen two edges late after a 0 three edges late.
    int m_edge = 0;
    int m_phase = 0;
    int m_dead = HPD_LOW_CYC;
    int m_rises = 0;
    int m_retry = 0;
    bit lk_h[3];
    bit al_h[3];
    bit vs_h[3];

    task automatic m_go(input int ph, input int dur);
        m_phase = ph;
        m_dead  = m_edge + dur;
        m_rises = 0;
    endtask

    initial forever begin
        @(posedge sys_clk or negedge rst_n);
        if (!rst_n) begin
            m_edge = 0;
            m_go(HPD_LOW, HPD_LOW_CYC);
            m_retry = 0;
            for (int i = 0; i < 3; i++) begin
                lk_h[i] = 1'b0;
                al_h[i] = 1'b0;
                vs_h[i] = 1'b0;
            end
        end else begin
            bit lk;
            bit al;
            bit rise;
            m_edge++;
            lk   = lk_h[1];
            al   = al_h[1];
            rise = vs_h[1] && !vs_h[2];
            if (rescan) begin
                m_go(HPD_LOW, HPD_LOW_CYC);
                m_retry = 0;
            end else begin
                case (m_phase)
                    HPD_LOW:    if (m_edge == m_dead) m_go(RST_HOLD, RST_HOLD_CYC);
                    RST_HOLD:   if (m_edge == m_dead) m_go(WAIT_LOCK, LOCK_TMO_CYC);
                    WAIT_LOCK: begin
                        if (lk) m_go(WAIT_ALIGN, ALIGN_TMO_CYC);
                        else if (m_edge == m_dead) m_go(FAIL, 0);
                    end
                    WAIT_ALIGN: begin
                        if (!lk) m_go(FAIL, 0);
                        else if (al) m_go(WAIT_VS, VS_TMO_CYC);
                        else if (m_edge == m_dead) m_go(FAIL, 0);
                    end
                    WAIT_VS: begin
                        if (!lk || !al) m_go(FAIL, 0);
                        else begin
                            if (rise) m_rises++;
                            if (m_rises >= 2) begin
                                m_go(RUN, VS_TMO_CYC);
                                m_retry = 0;
                            end else if (m_edge == m_dead) m_go(FAIL, 0);
                        end
                    end
                    RUN: begin
                        if (!lk || !al) m_go(FAIL, 0);
                        else if (rise) m_dead = m_edge + VS_TMO_CYC;
                        else if (m_edge == m_dead) m_go(FAIL, 0);
                    end
                    FAIL: begin
                        m_retry = (m_retry < MAX_RETRY) ? m_retry + 1 : MAX_RETRY;
                        if (m_retry == MAX_RETRY) m_go(HALT, 0);
                        else m_go(HPD_LOW, HPD_LOW_CYC);
                    end
                    default: begin
                    end
                endcase
            end
            for (int i = 2; i > 0; i--) begin
                lk_h[i] = lk_h[i-1];
                al_h[i] = al_h[i-1];
                vs_h[i] = vs_h[i-1];
            end
            lk_h[0] = rx_pll_locked;
            al_h[0] = rx_align_done;
            vs_h[0] = rx_vsync;
        end
    end

    // {hpd, rx_rst, tx_rst_n, oen, link_up, halted} for each phase
    function automatic logic [5:0] exp_outs(input int ph);
        case (ph)
            HPD_LOW:                       return 6'b010000;
            RST_HOLD:                      return 6'b110000;
            WAIT_LOCK, WAIT_ALIGN, WAIT_VS: return 6'b100000;
            RUN:                           return 6'b101110;
            FAIL:                          return 6'b110000;
            HALT:                          return 6'b010001;
            default:                       return 6'b010000;
        endcase
    endfunction

    initial forever begin
        logic [10:0] act_v;
        logic [10:0] exp_v;
        @(negedge sys_clk);
        act_v = {hdmi_in_hpd, rx_rst, tx_rst_n, hdmi_out_oen, link_up, halted, retry_cnt, state_o};
        exp_v = {exp_outs(m_phase), 2'(m_retry), 3'(m_phase)};
        tests++;
        if (act_v !== exp_v) begin
            fails++;
            if (fails < 30)
                $display("FAIL model_cycle %0d: hpd,rxrst,txrstn,oen,up,halt,retry,state got %b required %b",
                         cyc, act_v, exp_v);
        end
    end

    // ---------------- HPD low-time monitor ----------------
    int hpd_run = 0;
    int hpd_runs[$];

    initial forever begin
        @(negedge sys_clk);
        if (!rst_n) hpd_run = 0;
        else if (!hdmi_in_hpd) hpd_run++;
        else begin
            if (hpd_run > 0) hpd_runs.push_back(hpd_run);
            hpd_run = 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end else begin
            $display("[TB] %-24s got %0d required %0d", name, act, req);
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int bound, input string name);
        int n = 0;
        while (state_o != st && n < bound) begin
            @(negedge sys_clk);
            n++;
        end
        chk({"reach_", name}, int'(state_o), int'(st));
    endtask

    task automatic apply_reset();
        rx_pll_locked = 1'b0;
        rx_align_done = 1'b0;
        rescan = 1'b0;
        vs_en = 1'b0;
        @(posedge sys_clk);
        #3 rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_hpd"},      int'(hdmi_in_hpd), 0);
        chk({tag, "_rx_rst"},   int'(rx_rst), 1);
        chk({tag, "_tx_rst_n"}, int'(tx_rst_n), 0);
        chk({tag, "_oen"},      int'(hdmi_out_oen), 0);
        chk({tag, "_link_up"},  int'(link_up), 0);
        chk({tag, "_halted"},   int'(halted), 0);
        chk({tag, "_retry"},    int'(retry_cnt), 0);
        chk({tag, "_state"},    int'(state_o), int'(HPD_LOW));
    endtask

    // Assert reset between clock edges and look at the outputs before any edge arrives.
    task automatic async_reset_check(input string tag);
        @(posedge sys_clk);
        #3 rst_n = 1'b0;
        rx_pll_locked = 1'b0;
        rx_align_done = 1'b0;
        vs_en = 1'b0;
        #1 check_reset_values(tag);
        repeat (2) @(posedge sys_clk);
        #2 rst_n = 1'b1;
    endtask

    // Lock 20 cycles after RX reset release, align 20 later, vsync starting 10 after that.
    task automatic bring_up();
        wait_state(WAIT_LOCK, 400, "wait_lock");
        repeat (20) @(negedge sys_clk);
        rx_pll_locked = 1'b1;
        repeat (20) @(negedge sys_clk);
        rx_align_done = 1'b1;
        repeat (10) @(negedge sys_clk);
        vs_period = 30;
        vs_en = 1'b1;
    endtask

    initial begin
        int n;

        // 1: nominal bring-up
        apply_reset();
        check_reset_values("por");
        bring_up();
        wait_state(RUN, 200, "run_nominal");
        chk("nominal_link_up", int'(link_up), 1);
        chk("nominal_oen", int'(hdmi_out_oen), 1);
        chk("nominal_tx_rst_n", int'(tx_rst_n), 1);
        chk("nominal_retry", int'(retry_cnt), 0);
        repeat (100) @(negedge sys_clk);

        // 4: period 49 holds RUN; stopping vsync fails VS_TMO_CYC after the synchronised
        // rise, i.e. VS_TMO_CYC + 3 cycles after the raw rise (two sync flops + edge reg)
        vs_period = 49;
        repeat (300) @(negedge sys_clk);
        chk("vs49_still_run", int'(state_o), int'(RUN));
        vs_en = 1'b0;
        wait_state(FAIL, 200, "vs_timeout_fail");
        chk("vs_timeout_latency", cyc - last_rise, VS_TMO_CYC + 3);
        @(negedge sys_clk);
        chk("vs_timeout_state", int'(state_o), int'(HPD_LOW));
        chk("vs_timeout_retry", int'(retry_cnt), 1);

        // 3: one-cycle lock drop in RUN
        apply_reset();
        bring_up();
        wait_state(RUN, 200, "run_for_drop");
        repeat (10) @(negedge sys_clk);
        rx_pll_locked = 1'b0;
        @(negedge sys_clk);
        rx_pll_locked = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("lockdrop_oen", int'(hdmi_out_oen), 0);
        chk("lockdrop_state", int'(state_o), int'(HPD_LOW));
        chk("lockdrop_retry", int'(retry_cnt), 1);

        // 5: align arrives on the align-timeout cycle
        apply_reset();
        wait_state(WAIT_LOCK, 400, "wait_lock_t5");
        rx_pll_locked = 1'b1;
        wait_state(WAIT_ALIGN, 10, "wait_align_t5");
        repeat (ALIGN_TMO_CYC - 3) @(negedge sys_clk);
        rx_align_done = 1'b1;
        repeat (2) @(negedge sys_clk);
        chk("tie_before_state", int'(state_o), int'(WAIT_ALIGN));
        @(negedge sys_clk);
        chk("tie_success_state", int'(state_o), int'(WAIT_VS));
        repeat (60) @(negedge sys_clk);
        chk("tie_vs_timeout_retry", int'(retry_cnt), 1);

        // 2: lock never asserts -> HALT after three attempts
        apply_reset();
        hpd_runs.delete();
        wait_state(HALT, 1500, "halt");
        chk("halt_halted", int'(halted), 1);
        chk("halt_retry", int'(retry_cnt), MAX_RETRY);
        chk("halt_hpd", int'(hdmi_in_hpd), 0);
        chk("halt_hpd_low_count", hpd_runs.size(), 3);
        foreach (hpd_runs[i]) chk($sformatf("hpd_low_len_%0d", i), hpd_runs[i], HPD_LOW_CYC);
        repeat (20) @(negedge sys_clk);
        chk("halt_holds", int'(state_o), int'(HALT));
        rescan = 1'b1;
        @(negedge sys_clk);
        rescan = 1'b0;
        chk("rescan_state", int'(state_o), int'(HPD_LOW));
        chk("rescan_retry", int'(retry_cnt), 0);
        chk("rescan_halted", int'(halted), 0);
        repeat (50) @(negedge sys_clk);
        rescan = 1'b1;
        @(negedge sys_clk);
        rescan = 1'b0;
        n = 1;
        while (!hdmi_in_hpd && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        chk("rescan_restarts_hpd_low", n, HPD_LOW_CYC + 1);

        // 6: asynchronous reset in WAIT_VS and in RUN
        apply_reset();
        bring_up();
        wait_state(WAIT_VS, 100, "wait_vs_t6");
        async_reset_check("arst_wait_vs");
        @(negedge sys_clk);
        chk("arst_restart_state", int'(state_o), int'(HPD_LOW));
        bring_up();
        wait_state(RUN, 200, "run_t6");
        async_reset_check("arst_run");
        repeat (150) @(negedge sys_clk);
        chk("arst_restart_hpd", int'(hdmi_in_hpd), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
